mux_rr_bus: RTL and testbench



---
 rtl/mux_rr_pkg.sv | 19 +
 rtl/mux_rr_bus_rr_pick.sv | 30 +++
 rtl/mux_rr_bus.sv | 107 ++++++++++
 tb/tb_mux_rr_bus.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mux_rr_pkg.sv
// Shared types and constants for the round-robin bus multiplexer.
// Optional tristate idle drive is enabled with MUX_RR_TRISTATE_EN.
package mux_rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_HOLD  = 2;

    // Counter width that never collapses to zero bits
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_rr_bus_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
// Part of mux_rr_bus (MUX_RR_TRISTATE_EN has no effect here).
module rr_pick
    import mux_rr_pkg::*;
#(
    parameter int NCH = DEF_NCH
) (
    input  logic [NCH-1:0]     req,
    input  logic [cw(NCH)-1:0] ptr,
    output logic [cw(NCH)-1:0] idx,
    output logic               found
);

    localparam int PW = cw(NCH);

    // Walk offsets downward so the smallest offset from ptr wins
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % NCH;
            if (req[j]) begin
                idx   = PW'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_bus.sv
// Registered N-channel round-robin bus mux with bounded bursts per grant.
// Define MUX_RR_TRISTATE_EN to float dout instead of driving 0 when idle.
module mux_rr_bus
    import mux_rr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int HOLD  = DEF_HOLD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*WIDTH-1:0]   din,
    output logic [NCH-1:0]         ack,
    output logic [WIDTH-1:0]       dout,
    output logic                   dvalid,
    output logic [cw(NCH)-1:0]     grant_id
);

    localparam int PW = cw(NCH);
    localparam int BW = cw(HOLD + 1);

    state_t           state_q, state_d;
    logic [PW-1:0]    gnt_q, gnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic             dvalid_q, dvalid_d;
    logic [PW-1:0]    gid_q, gid_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [PW-1:0]    pick_idx;
    logic             pick_found;
    logic             req_g;

    rr_pick #(.NCH(NCH)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        beat_d   = beat_q;
        dvalid_d = 1'b0;
        gid_d    = gid_q;
        data_d   = data_q;
        ack      = '0;
        req_g    = req[gnt_q];
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d   = pick_idx;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                ack[gnt_q] = req_g;
                if (req_g) begin
                    data_d   = din[int'(gnt_q)*WIDTH +: WIDTH];
                    dvalid_d = 1'b1;
                    gid_d    = gnt_q;
                    beat_d   = beat_q + 1'b1;
                end
                // A dropped request releases without emitting a beat
                if (!req_g || beat_d == BW'(HOLD)) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == PW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            beat_q   <= '0;
            dvalid_q <= 1'b0;
            gid_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            beat_q   <= beat_d;
            dvalid_q <= dvalid_d;
            gid_q    <= gid_d;
            data_q   <= data_d;
        end
    end

    assign dvalid   = dvalid_q;
    assign grant_id = gid_q;

`ifdef MUX_RR_TRISTATE_EN
    assign dout = dvalid_q ? data_q : {WIDTH{1'bz}};
`else
    assign dout = dvalid_q ? data_q : '0;
`endif

endmodule

// File: tb/tb_mux_rr_bus.sv
// Directed bench for mux_rr_bus with NCH=4, WIDTH=8, HOLD=2.
// Idle dout expectation follows MUX_RR_TRISTATE_EN.
module tb_mux_rr_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  ack;
    logic [7:0]  dout;
    logic        dvalid;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;
    int nbeats = 0;
    logic [7:0] idle_v;

    always #5 clk = ~clk;

    mux_rr_bus #(.WIDTH(8), .NCH(4), .HOLD(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .din      (din),
        .ack      (ack),
        .dout     (dout),
        .dvalid   (dvalid),
        .grant_id (grant_id)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, check mid-cycle, advance past the edge
    task automatic cyc(input string tag, input logic [3:0] r,
                       input logic rs, input logic [3:0] e_ack,
                       input logic e_dv, input logic [7:0] e_d,
                       input logic [1:0] e_gid);
        req   = r;
        reset = rs;
        @(negedge clk);
        nbeats += $countones(ack);
        chk({tag, ".ack"}, {4'b0, ack}, {4'b0, e_ack});
        chk({tag, ".dvalid"}, {7'b0, dvalid}, {7'b0, e_dv});
        chk({tag, ".dout"}, dout, e_dv ? e_d : idle_v);
        chk({tag, ".gid"}, {6'b0, grant_id}, {6'b0, e_gid});
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MUX_RR_TRISTATE_EN
        idle_v = 8'bzzzzzzzz;
`else
        idle_v = 8'h00;
`endif
        din   = {8'h44, 8'hA5, 8'h22, 8'h11};
        req   = 4'b1111;
        reset = 1'b1;
        @(posedge clk);
        #1;

        cyc("rst0", 4'b1111, 1, 4'h0, 0, 8'h00, 2'd0);
        cyc("rst1", 4'b1111, 1, 4'h0, 0, 8'h00, 2'd0);

        // Full rotation with all requests held
        nbeats = 0;
        cyc("rot0",  4'b1111, 0, 4'h0, 0, 8'h00, 2'd0);
        cyc("rot1",  4'b1111, 0, 4'h1, 0, 8'h00, 2'd0);
        cyc("rot2",  4'b1111, 0, 4'h1, 1, 8'h11, 2'd0);
        cyc("rot3",  4'b1111, 0, 4'h0, 1, 8'h11, 2'd0);
        cyc("rot4",  4'b1111, 0, 4'h2, 0, 8'h00, 2'd0);
        cyc("rot5",  4'b1111, 0, 4'h2, 1, 8'h22, 2'd1);
        cyc("rot6",  4'b1111, 0, 4'h0, 1, 8'h22, 2'd1);
        cyc("rot7",  4'b1111, 0, 4'h4, 0, 8'h00, 2'd1);
        cyc("rot8",  4'b1111, 0, 4'h4, 1, 8'hA5, 2'd2);
        cyc("rot9",  4'b1111, 0, 4'h0, 1, 8'hA5, 2'd2);
        cyc("rot10", 4'b1111, 0, 4'h8, 0, 8'h00, 2'd2);
        cyc("rot11", 4'b1111, 0, 4'h8, 1, 8'h44, 2'd3);
        chk("beats12", nbeats[7:0], 8'd8);
        cyc("rot12", 4'b1111, 0, 4'h0, 1, 8'h44, 2'd3);
        cyc("rot13", 4'b1111, 0, 4'h1, 0, 8'h00, 2'd3);
        cyc("rot14", 4'b1111, 0, 4'h1, 1, 8'h11, 2'd0);
        cyc("rot15", 4'b1111, 0, 4'h0, 1, 8'h11, 2'd0);
        cyc("rot16", 4'b1111, 0, 4'h2, 0, 8'h00, 2'd0);

        // Reset right after ch1's first beat: no second beat, restart at ch0
        cyc("mrst0", 4'b1111, 1, 4'h2, 1, 8'h22, 2'd1);
        cyc("mrst1", 4'b1111, 0, 4'h0, 0, 8'h00, 2'd0);
        cyc("mrst2", 4'b1111, 0, 4'h1, 0, 8'h00, 2'd0);
        cyc("mrst3", 4'b1111, 0, 4'h1, 1, 8'h11, 2'd0);
        cyc("flush0", 4'b0000, 0, 4'h0, 1, 8'h11, 2'd0);
        cyc("flush1", 4'b0000, 0, 4'h0, 0, 8'h00, 2'd0);

        // Only ch2 requesting: burst, bubble, re-grant
        cyc("ch2_0", 4'b0100, 0, 4'h0, 0, 8'h00, 2'd0);
        cyc("ch2_1", 4'b0100, 0, 4'h4, 0, 8'h00, 2'd0);
        cyc("ch2_2", 4'b0100, 0, 4'h4, 1, 8'hA5, 2'd2);
        cyc("ch2_3", 4'b0100, 0, 4'h0, 1, 8'hA5, 2'd2);
        cyc("ch2_4", 4'b0100, 0, 4'h4, 0, 8'h00, 2'd2);
        cyc("ch2_5", 4'b0100, 0, 4'h4, 1, 8'hA5, 2'd2);
        cyc("ch2_6", 4'b0000, 0, 4'h0, 1, 8'hA5, 2'd2);
        cyc("ch2_7", 4'b0000, 0, 4'h0, 0, 8'h00, 2'd2);

        // ch1 drops after one beat while ch3 waits; ch3 then drops early
        cyc("drop0", 4'b0010, 0, 4'h0, 0, 8'h00, 2'd2);
        cyc("drop1", 4'b1010, 0, 4'h2, 0, 8'h00, 2'd2);
        cyc("drop2", 4'b1000, 0, 4'h0, 1, 8'h22, 2'd1);
        cyc("drop3", 4'b1000, 0, 4'h0, 0, 8'h00, 2'd1);
        cyc("drop4", 4'b1000, 0, 4'h8, 0, 8'h00, 2'd1);
        cyc("drop5", 4'b0000, 0, 4'h0, 1, 8'h44, 2'd3);
        cyc("drop6", 4'b0000, 0, 4'h0, 0, 8'h00, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
